// File: rtl/axil_slave_if.sv
// AXI-Lite bus bundle between an AXI-Lite master and the axil_slave responder.
// Carries the five AXI-Lite channels (AW, W, B, AR, R); protection fields are
// carried but ignored by the responder.
//   slave  modport: seen from the responder (inputs = master-driven signals)
//   master modport: seen from the bus master
interface axil_slave_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );
endinterface

// File: rtl/axil_slave.sv
// AXI-Lite responder bridging to a single req/ack register-access backend.
// One outstanding read and one outstanding write; reads and writes share the
// backend and are serialised with alternating priority. A backend access that
// is not acknowledged within TIMEOUT_CYCLES completes with SLVERR.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   s_axil         AXI-Lite slave port (axil_slave_if.slave)
//   reg_req        backend request level, held until ack or timeout
//   reg_wen        1 write, 0 read
//   reg_addr/wdata/wstrb  backend access payload, stable while reg_req=1
//   reg_rdata      backend read data, sampled with reg_ack
//   reg_ack        backend completion
//   reg_err        backend error, qualified by reg_ack
module axil_slave #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    axil_slave_if.slave           s_axil,
    output logic                  reg_req,
    output logic                  reg_wen,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic [STRB_WIDTH-1:0] reg_wstrb,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_ack,
    input  logic                  reg_err
);
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ACC  = 3'd1;
    localparam logic [2:0] RD_ACC  = 3'd2;
    localparam logic [2:0] WR_RESP = 3'd3;
    localparam logic [2:0] RD_RESP = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]            state_q, state_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  last_wr_q, last_wr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  reg_req_d, reg_wen_d;
    logic [ADDR_WIDTH-1:0] reg_addr_d;
    logic [DATA_WIDTH-1:0] reg_wdata_d;
    logic [STRB_WIDTH-1:0] reg_wstrb_d;

    logic wr_rdy, rd_rdy, grant_wr, grant_rd, timed_out, ack_ok;
    logic unused_prot;

    assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.arready = arready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;

    // Arbitration: alternate when both directions are ready
    assign wr_rdy    = aw_held_q & w_held_q;
    assign rd_rdy    = ar_held_q;
    assign grant_wr  = wr_rdy & (~rd_rdy | ~last_wr_q);
    assign grant_rd  = rd_rdy & (~wr_rdy | last_wr_q);
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));
    assign ack_ok    = reg_ack & ~reg_err;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            ar_held_q <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            last_wr_q <= 1'b0;
            cnt_q     <= '0;
            reg_req   <= 1'b0;
            reg_wen   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wstrb <= '0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            ar_held_q <= ar_held_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            last_wr_q <= last_wr_d;
            cnt_q     <= cnt_d;
            reg_req   <= reg_req_d;
            reg_wen   <= reg_wen_d;
            reg_addr  <= reg_addr_d;
            reg_wdata <= reg_wdata_d;
            reg_wstrb <= reg_wstrb_d;
        end
    end

    // Capture, next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        ar_held_d   = ar_held_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        rvalid_d    = rvalid_q;
        bresp_d     = bresp_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        last_wr_d   = last_wr_q;
        cnt_d       = cnt_q;
        reg_req_d   = reg_req;
        reg_wen_d   = reg_wen;
        reg_addr_d  = reg_addr;
        reg_wdata_d = reg_wdata;
        reg_wstrb_d = reg_wstrb;

        // One-deep holding registers; ready is low only while an entry is held
        if (s_axil.awvalid && awready_q) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axil.awaddr;
        end
        if (s_axil.wvalid && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = s_axil.wdata;
            wstrb_d  = s_axil.wstrb;
        end
        if (s_axil.arvalid && arready_q) begin
            ar_held_d = 1'b1;
            araddr_d  = s_axil.araddr;
        end

        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    reg_req_d   = 1'b1;
                    reg_wen_d   = 1'b1;
                    reg_addr_d  = awaddr_q;
                    reg_wdata_d = wdata_q;
                    reg_wstrb_d = wstrb_q;
                    aw_held_d   = 1'b0;
                    w_held_d    = 1'b0;
                    last_wr_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = WR_ACC;
                end else if (grant_rd) begin
                    reg_req_d   = 1'b1;
                    reg_wen_d   = 1'b0;
                    reg_addr_d  = araddr_q;
                    reg_wdata_d = '0;
                    reg_wstrb_d = '0;
                    ar_held_d   = 1'b0;
                    last_wr_d   = 1'b0;
                    cnt_d       = '0;
                    state_d     = RD_ACC;
                end
            end
            WR_ACC, RD_ACC: begin
                // An ack in the timeout cycle still wins
                if (reg_ack || timed_out) begin
                    reg_req_d = 1'b0;
                    if (state_q == RD_ACC) begin
                        rresp_d  = ack_ok ? RESP_OKAY : RESP_SLVERR;
                        rdata_d  = ack_ok ? reg_rdata : '0;
                        rvalid_d = 1'b1;
                        state_d  = RD_RESP;
                    end else begin
                        bresp_d  = ack_ok ? RESP_OKAY : RESP_SLVERR;
                        bvalid_d = 1'b1;
                        state_d  = WR_RESP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_RESP: begin
                if (s_axil.bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RD_RESP: begin
                if (s_axil.rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        awready_d = ~aw_held_d;
        wready_d  = ~w_held_d;
        arready_d = ~ar_held_d;
    end
endmodule

// File: tb/tb_axil_slave.sv
// Directed self-checking bench for axil_slave with a simple backend responder.
module tb_axil_slave;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axil_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) s_axil ();

    logic          reg_req, reg_wen, reg_ack, reg_err;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata, reg_rdata;
    logic [SW-1:0] reg_wstrb;

    axil_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_axil    (s_axil),
        .reg_req   (reg_req),
        .reg_wen   (reg_wen),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wstrb (reg_wstrb),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .reg_err   (reg_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Backend model: acks bk_delay cycles after reg_req rises, logs each access
    int            bk_delay = 0;
    bit            bk_en    = 1'b1;
    bit            bk_err   = 1'b0;
    logic [DW-1:0] bk_rdata = '0;
    int            req_cyc  = 0;
    int            n_wr     = 0;
    int            last_len = 0;
    logic [SW-1:0] last_strb = '0;
    logic          acc_wen[$];

    initial begin
        reg_ack   = 1'b0;
        reg_err   = 1'b0;
        reg_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reg_req) begin
                if (req_cyc == 0) begin
                    acc_wen.push_back(reg_wen);
                    if (reg_wen) n_wr++;
                    last_strb = reg_wstrb;
                end
                reg_ack   = bk_en && (req_cyc == bk_delay);
                reg_err   = bk_err;
                reg_rdata = bk_rdata;
                req_cyc++;
            end else begin
                if (req_cyc != 0) last_len = req_cyc;
                req_cyc = 0;
                reg_ack = 1'b0;
            end
        end
    end

    task automatic send_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        int k = 0;
        s_axil.awaddr  = a;
        s_axil.wdata   = d;
        s_axil.wstrb   = s;
        s_axil.awvalid = 1'b1;
        s_axil.wvalid  = 1'b1;
        while (!(aw_done && w_done) && k < 50) begin
            if (s_axil.awready) aw_done = 1'b1;
            if (s_axil.wready)  w_done  = 1'b1;
            tick();
            k++;
            if (aw_done) s_axil.awvalid = 1'b0;
            if (w_done)  s_axil.wvalid  = 1'b0;
        end
        check("send_wr_hs", 64'({aw_done, w_done}), 64'd3);
    endtask

    task automatic send_rd(input logic [AW-1:0] a);
        bit done = 1'b0;
        int k = 0;
        s_axil.araddr  = a;
        s_axil.arvalid = 1'b1;
        while (!done && k < 50) begin
            if (s_axil.arready) done = 1'b1;
            tick();
            k++;
        end
        s_axil.arvalid = 1'b0;
        check("send_rd_hs", 64'(done), 64'd1);
    endtask

    task automatic wait_b(input string tag);
        int k = 0;
        while (!s_axil.bvalid && k < 100) begin
            tick();
            k++;
        end
        check(tag, 64'(s_axil.bvalid), 64'd1);
    endtask

    task automatic wait_r(input string tag);
        int k = 0;
        while (!s_axil.rvalid && k < 100) begin
            tick();
            k++;
        end
        check(tag, 64'(s_axil.rvalid), 64'd1);
    endtask

    task automatic finish_b();
        s_axil.bready = 1'b1;
        tick();
        s_axil.bready = 1'b0;
        check("b_drop", 64'(s_axil.bvalid), 64'd0);
    endtask

    task automatic finish_r();
        s_axil.rready = 1'b1;
        tick();
        s_axil.rready = 1'b0;
        check("r_drop", 64'(s_axil.rvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int w0;
        int k;
        s_axil.awaddr = '0; s_axil.awprot = '0; s_axil.awvalid = 1'b0;
        s_axil.wdata  = '0; s_axil.wstrb  = '0; s_axil.wvalid  = 1'b0;
        s_axil.bready = 1'b0;
        s_axil.araddr = '0; s_axil.arprot = '0; s_axil.arvalid = 1'b0;
        s_axil.rready = 1'b0;

        // Reset values
        #1;
        check("rst_awready", 64'(s_axil.awready), 64'd0);
        check("rst_arready", 64'(s_axil.arready), 64'd0);
        check("rst_bvalid",  64'(s_axil.bvalid),  64'd0);
        check("rst_rvalid",  64'(s_axil.rvalid),  64'd0);
        check("rst_req",     64'(reg_req),        64'd0);
        repeat (2) tick();
        rstn = 1'b1;
        check("rel_awready_0", 64'(s_axil.awready), 64'd0);
        tick();
        check("rel_awready_1", 64'(s_axil.awready), 64'd1);
        check("rel_wready_1",  64'(s_axil.wready),  64'd1);
        check("rel_arready_1", 64'(s_axil.arready), 64'd1);

        // 1: AW+W same cycle N, ack at first req cycle
        bk_delay = 0;
        s_axil.awaddr = 32'h10; s_axil.wdata = 32'hDEADBEEF; s_axil.wstrb = 4'hF;
        s_axil.awvalid = 1'b1; s_axil.wvalid = 1'b1;
        check("t1_req_n", 64'(reg_req), 64'd0);
        tick();
        s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
        check("t1_awready_n1", 64'(s_axil.awready), 64'd0);
        check("t1_wready_n1",  64'(s_axil.wready),  64'd0);
        check("t1_req_n1",     64'(reg_req),        64'd0);
        tick();
        check("t1_req_n2",   64'(reg_req),   64'd1);
        check("t1_wen_n2",   64'(reg_wen),   64'd1);
        check("t1_addr_n2",  64'(reg_addr),  64'h10);
        check("t1_wdata_n2", 64'(reg_wdata), 64'hDEADBEEF);
        check("t1_wstrb_n2", 64'(reg_wstrb), 64'hF);
        check("t1_bvalid_n2", 64'(s_axil.bvalid), 64'd0);
        tick();
        check("t1_bvalid_n3", 64'(s_axil.bvalid), 64'd1);
        check("t1_bresp_n3",  64'(s_axil.bresp),  64'd0);
        check("t1_req_n3",    64'(reg_req),       64'd0);
        check("t1_awready_n3", 64'(s_axil.awready), 64'd1);
        finish_b();

        // 2: W three cycles ahead of AW, wstrb=0 forwarded unchanged
        w0 = n_wr;
        s_axil.wdata = 32'h0BADF00D; s_axil.wstrb = 4'h0; s_axil.wvalid = 1'b1;
        check("t2_wready_hs", 64'(s_axil.wready), 64'd1);
        tick();
        s_axil.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_wready_hold", 64'(s_axil.wready), 64'd0);
            check("t2_req_hold",    64'(reg_req),       64'd0);
            if (i == 2) begin
                s_axil.awaddr = 32'h40; s_axil.awvalid = 1'b1;
            end
            tick();
        end
        s_axil.awvalid = 1'b0;
        wait_b("t2_bvalid");
        check("t2_bresp",   64'(s_axil.bresp), 64'd0);
        check("t2_one_wr",  64'(n_wr - w0),    64'd1);
        check("t2_strb0",   64'(last_strb),    64'd0);
        finish_b();
        check("t2_wready_back", 64'(s_axil.wready), 64'd1);

        // 3: read with ack 2 cycles after req, rready held low 4 cycles
        bk_delay = 2; bk_rdata = 32'h12345678;
        send_rd(32'h20);
        wait_r("t3_rvalid");
        for (int i = 0; i < 4; i++) begin
            check("t3_rvalid_hold", 64'(s_axil.rvalid), 64'd1);
            check("t3_rdata_hold",  64'(s_axil.rdata),  64'h12345678);
            check("t3_rresp_hold",  64'(s_axil.rresp),  64'd0);
            tick();
        end
        check("t3_req_len", 64'(last_len), 64'd3);
        finish_r();

        // 4: read and write pending together after a write grant -> read first
        bk_delay = 4;
        base = acc_wen.size();
        send_wr(32'h100, 32'h11111111, 4'hF);
        send_rd(32'h104);
        send_wr(32'h108, 32'h22222222, 4'h3);
        s_axil.bready = 1'b1; s_axil.rready = 1'b1;
        k = 0;
        while (acc_wen.size() < base + 3 && k < 200) begin
            tick();
            k++;
        end
        check("t4_three_acc", 64'(acc_wen.size() >= base + 3), 64'd1);
        repeat (12) tick();
        s_axil.bready = 1'b0; s_axil.rready = 1'b0;
        if (acc_wen.size() >= base + 3) begin
            check("t4_first_wr",  64'(acc_wen[base]),     64'd1);
            check("t4_second_rd", 64'(acc_wen[base + 1]), 64'd0);
            check("t4_third_wr",  64'(acc_wen[base + 2]), 64'd1);
        end
        check("t4_idle_req", 64'(reg_req), 64'd0);

        // 5: no ack -> timeout after 16 request cycles; then read with error
        bk_en = 1'b0;
        send_wr(32'h200, 32'hA0A0A0A0, 4'hF);
        wait_b("t5_bvalid");
        check("t5_bresp", 64'(s_axil.bresp), 64'd2);
        finish_b();
        check("t5_req_len", 64'(last_len), 64'd16);
        bk_en = 1'b1; bk_err = 1'b1; bk_delay = 0; bk_rdata = 32'hCAFEF00D;
        send_rd(32'h204);
        wait_r("t5_rvalid_err");
        check("t5_rresp", 64'(s_axil.rresp), 64'd2);
        check("t5_rdata", 64'(s_axil.rdata), 64'd0);
        finish_r();
        bk_err = 1'b0;

        // 6: reset while rvalid=1, then a normal read
        bk_rdata = 32'h0000A5A5;
        send_rd(32'h300);
        wait_r("t6_rvalid");
        rstn = 1'b0;
        #1;
        check("t6_rvalid_rst",  64'(s_axil.rvalid),  64'd0);
        check("t6_arready_rst", 64'(s_axil.arready), 64'd0);
        check("t6_awready_rst", 64'(s_axil.awready), 64'd0);
        check("t6_wready_rst",  64'(s_axil.wready),  64'd0);
        tick();
        rstn = 1'b1;
        check("t6_arready_rel", 64'(s_axil.arready), 64'd0);
        tick();
        check("t6_arready_up", 64'(s_axil.arready), 64'd1);
        check("t6_rvalid_up",  64'(s_axil.rvalid),  64'd0);
        bk_rdata = 32'h5A5A0001;
        send_rd(32'h304);
        wait_r("t6_rvalid_new");
        check("t6_rdata", 64'(s_axil.rdata), 64'h5A5A0001);
        check("t6_rresp", 64'(s_axil.rresp), 64'd0);
        finish_r();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
